// File: rtl/vcu_pkg.sv
// Shared definitions for the display responder: FSM states, control bits, status layout.
// No logic of its own; pure types, constants and a status packing helper.
// Not applicable to backpressure.
package vcu_pkg;

  localparam logic [27:0] TICK_LOAD_DEF = 28'h2FAF080;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // control word bit positions
  localparam int CTL_ENABLE   = 0;
  localparam int CTL_FLUSH    = 1;
  localparam int CTL_TICK_RST = 2;
  localparam int CTL_OVF_CLR  = 3;

  // status word field positions
  localparam int STS_TICK_DONE = 0;
  localparam int STS_EMPTY     = 1;
  localparam int STS_FULL      = 2;
  localparam int STS_OVF       = 3;
  localparam int STS_CNT_LSB   = 4;
  localparam int STS_LAST_LSB  = 8;
  localparam int STS_DVALID    = 16;

  localparam logic [31:0] STATUS_RESET = 32'h0000_0002;

  function automatic logic [31:0] pack_status(
    input logic       tick_done,
    input logic       empty,
    input logic       full,
    input logic       overflow,
    input logic [3:0] count,
    input logic [7:0] last_byte,
    input logic       disp_valid
  );
    logic [31:0] s;
    s = 32'd0;
    s[STS_TICK_DONE]              = tick_done;
    s[STS_EMPTY]                  = empty;
    s[STS_FULL]                   = full;
    s[STS_OVF]                    = overflow;
    s[STS_CNT_LSB +: 4]           = count;
    s[STS_LAST_LSB +: 8]          = last_byte;
    s[STS_DVALID]                 = disp_valid;
    return s;
  endfunction

endpackage

// File: rtl/vcu_fifo.sv
// Byte FIFO holding display data, with single-cycle flush and drop reporting.
// Head byte is visible combinationally on dout; push/pop take effect at the next edge.
// A push into a full FIFO is accepted only if a pop frees a slot that same cycle, else dropped.
module vcu_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count,
  output logic       drop
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr;
  logic          rd;

  assign full  = (count == DEPTH_C);
  assign empty = (count == 4'd0);
  assign rd    = pop && !empty;
  // a flush swallows any concurrent push without counting it as an overflow
  assign wr    = push && !flush && (!full || rd);
  assign drop  = push && !flush && full && !rd;
  assign dout  = mem[rd_ptr];

  // pointer and occupancy tracking; flush wins over everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {3'd0, wr} - {3'd0, rd};
    end
  end

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vcu_responder.sv
// CPU-fed display responder: queues bytes and presents one per tick interval to a sink.
// Status word is registered (1 cycle); a byte is popped one cycle before disp_valid rises.
// disp_data is held while disp_ready is low; a full FIFO drops pushes and flags overflow.
module vcu_responder
  import vcu_pkg::*;
#(
  parameter logic [27:0] TICK_LOAD  = TICK_LOAD_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] vcu_reg_control,
  input  logic        vcu_reg_control_we,
  input  logic [31:0] vcu_reg_wdata,
  input  logic        vcu_reg_wdata_we,
  output logic [31:0] vcu_reg_rdata,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ready
);

  state_t      state;
  logic        enable;
  logic        overflow;
  logic [27:0] tick_cnt;
  logic [7:0]  last_byte;

  logic        tick_done;
  logic        handshake;
  logic        pop;
  logic        tick_load;
  logic        ctl_flush;
  logic        ctl_ovf_clr;
  logic        ctl_tick_rst;

  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_count;
  logic        fifo_drop;

  logic        unused_bits;
  assign unused_bits = ^{vcu_reg_control[31:4], vcu_reg_wdata[31:8]};

  assign ctl_flush    = vcu_reg_control_we && vcu_reg_control[CTL_FLUSH];
  assign ctl_tick_rst = vcu_reg_control_we && vcu_reg_control[CTL_TICK_RST];
  assign ctl_ovf_clr  = vcu_reg_control_we && vcu_reg_control[CTL_OVF_CLR];

  // counter underflows into bit 27, which then freezes it until the next load
  assign tick_done = tick_cnt[27];
  assign handshake = (state == ST_PRESENT) && disp_ready;
  assign pop       = (state == ST_IDLE) && enable && !fifo_empty && tick_done;
  assign tick_load = vcu_reg_wdata_we || ctl_tick_rst || handshake;

  vcu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vcu_reg_wdata_we),
    .pop   (pop),
    .flush (ctl_flush),
    .din   (vcu_reg_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  // inter-byte pacing counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= TICK_LOAD;
    else if (tick_load)        tick_cnt <= TICK_LOAD;
    else if (!tick_cnt[27])    tick_cnt <= tick_cnt - 28'd1;
  end

  // held enable bit and sticky overflow flag (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (vcu_reg_control_we) enable <= vcu_reg_control[CTL_ENABLE];
      if (fifo_drop)          overflow <= 1'b1;
      else if (ctl_ovf_clr)   overflow <= 1'b0;
    end
  end

  // presentation FSM; once a byte is presented only the sink (or reset) can retire it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      last_byte  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state      <= ST_PRESENT;
            disp_valid <= 1'b1;
            disp_data  <= fifo_dout;
          end
        end
        ST_PRESENT: begin
          if (disp_ready) begin
            state      <= ST_IDLE;
            disp_valid <= 1'b0;
            last_byte  <= disp_data;
          end
        end
        default: begin
          state      <= ST_IDLE;
          disp_valid <= 1'b0;
        end
      endcase
    end
  end

  // CPU-visible status snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vcu_reg_rdata <= STATUS_RESET;
    else        vcu_reg_rdata <= pack_status(tick_done, fifo_empty, fifo_full, overflow,
                                             fifo_count, last_byte, disp_valid);
  end

endmodule

// File: tb/tb_vcu_responder.sv
// Randomised and directed bench for vcu_responder against a queue-based behavioural model.
// Model outputs are compared on every falling edge while out of reset.
// Exercises sink stalls, full FIFO, flush, overflow and async reset mid-presentation.
module tb_vcu_responder;

  localparam int TL    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl = 32'd0;
  logic        ctrl_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        wdata_we = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  vcu_responder #(.TICK_LOAD(28'h10), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .vcu_reg_control    (ctrl),
    .vcu_reg_control_we (ctrl_we),
    .vcu_reg_wdata      (wdata),
    .vcu_reg_wdata_we   (wdata_we),
    .vcu_reg_rdata      (rdata),
    .disp_data          (disp_data),
    .disp_valid         (disp_valid),
    .disp_ready         (disp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_q[$];
  bit          m_ovf, m_en, m_pres;
  logic [7:0]  m_byte, m_last;
  int          m_age;      // cycles since the pacing interval was last restarted
  logic [31:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    bit         done, hs, pop, flush;
    int         sz;
    logic [7:0] head;
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_en = 0; m_pres = 0;
      m_byte = 8'h00; m_last = 8'h00;
      m_age = 0;
      m_rdata = 32'h2;
    end else begin
      done  = (m_age >= TL + 1);
      hs    = m_pres && disp_ready;
      sz    = m_q.size();
      pop   = !m_pres && m_en && sz > 0 && done;
      flush = ctrl_we && ctrl[1];
      head  = 8'h00;
      m_rdata = {15'd0, m_pres, m_last, 4'(sz), m_ovf, (sz == DEPTH), (sz == 0), done};
      if (pop) head = m_q.pop_front();
      if (flush) m_q.delete();
      if (wdata_we && !flush) begin
        if (sz < DEPTH || pop) m_q.push_back(wdata[7:0]);
        else m_ovf = 1;
      end else if (ctrl_we && ctrl[3]) begin
        m_ovf = 0;
      end
      if (wdata_we && !flush && !(sz < DEPTH || pop)) m_ovf = 1;
      else if (ctrl_we && ctrl[3]) m_ovf = 0;
      if (ctrl_we) m_en = ctrl[0];
      if (wdata_we || (ctrl_we && ctrl[2]) || hs) m_age = 0;
      else if (m_age < 1000) m_age++;
      if (hs) begin m_pres = 0; m_last = m_byte; end
      if (pop) begin m_pres = 1; m_byte = head; end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (rst_n) begin
      check("disp_valid", 32'(disp_valid), 32'(m_pres));
      if (m_pres) check("disp_data", 32'(disp_data), 32'(m_byte));
      check("rdata", rdata, m_rdata);
    end
  end

  // accepted-byte log and spacing check
  logic [7:0] hs_bytes[$];
  int cyc = 0;
  int last_hs = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_hs = -1;
    end else begin
      cyc++;
      if (disp_valid && disp_ready) begin
        hs_bytes.push_back(disp_data);
        if (last_hs >= 0) check("hs_spacing_ok", 32'((cyc - last_hs) >= TL + 2), 32'd1);
        last_hs = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    @(negedge clk); ctrl = v; ctrl_we = 1'b1;
    @(negedge clk); ctrl_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); wdata = {24'd0, b}; wdata_we = 1'b1;
    @(negedge clk); wdata_we = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k = 0;
    while (hs_bytes.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    check(name, 32'(hs_bytes.size()), 32'(n));
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!disp_valid && k < budget) begin
      @(negedge clk); k++;
    end
    check(name, 32'(disp_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    // reset state
    cyc_n(3);
    #1;
    check("reset_rdata", rdata, 32'h2);
    check("reset_valid", 32'(disp_valid), 32'd0);
    check("reset_data", 32'(disp_data), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // tick expiry after release
    repeat (17) @(negedge clk);
    check("tick_pre", rdata, 32'h2);
    @(negedge clk);
    check("tick_post", rdata, 32'h3);

    // overflow: five pushes into a four-deep FIFO with output disabled
    for (int i = 1; i <= 5; i++) push(8'(i));
    cyc_n(2);
    check("ovf_full", 32'(rdata[2]), 32'd1);
    check("ovf_count", 32'(rdata[7:4]), 32'd4);
    check("ovf_flag", 32'(rdata[3]), 32'd1);
    write_ctrl(32'h8);
    cyc_n(2);
    check("ovf_cleared", 32'(rdata[3]), 32'd0);
    check("ovf_count_kept", 32'(rdata[7:4]), 32'd4);
    hs_bytes.delete();
    disp_ready = 1'b1;
    write_ctrl(32'h1);
    wait_hs(4, 200, "drain_count");
    for (int i = 0; i < 4 && i < hs_bytes.size(); i++)
      check("drain_byte", 32'(hs_bytes[i]), 32'(i + 1));

    // single byte presentation
    hs_bytes.delete();
    push(8'hA5);
    wait_hs(1, 100, "a5_count");
    if (hs_bytes.size() > 0) check("a5_byte", 32'(hs_bytes[0]), 32'hA5);
    cyc_n(2);
    check("a5_last", 32'(rdata[15:8]), 32'hA5);

    // sink stall holds the presented byte
    disp_ready = 1'b0;
    write_ctrl(32'h0);
    push(8'h11); push(8'h22); push(8'h33);
    hs_bytes.delete();
    write_ctrl(32'h1);
    wait_valid(100, "stall_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", 32'(disp_data), 32'h11);
    end
    disp_ready = 1'b1;
    wait_hs(3, 200, "stall_count");
    for (int i = 0; i < 3 && i < hs_bytes.size(); i++)
      check("stall_byte", 32'(hs_bytes[i]), 32'((i + 1) * 8'h11));

    // simultaneous pop and push on a full FIFO
    disp_ready = 1'b0;
    write_ctrl(32'h0);
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    cyc_n(20);
    @(negedge clk); ctrl = 32'h1; ctrl_we = 1'b1;
    @(negedge clk); ctrl_we = 1'b0; wdata = 32'h45; wdata_we = 1'b1;
    @(negedge clk); wdata_we = 1'b0;
    cyc_n(2);
    check("pp_count", 32'(rdata[7:4]), 32'd4);
    check("pp_ovf", 32'(rdata[3]), 32'd0);
    check("pp_valid", 32'(disp_valid), 32'd1);
    check("pp_data", 32'(disp_data), 32'h41);

    // asynchronous reset while presenting
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 32'(disp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc_n(2);
    check("arst_rdata", rdata, 32'h2);

    // randomised traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      wdata_we   = ($urandom_range(99) < 30);
      wdata      = $urandom;
      ctrl_we    = ($urandom_range(99) < 6);
      ctrl       = {28'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                    ($urandom_range(3) == 0), ($urandom_range(99) < 85)};
      disp_ready = ($urandom_range(99) < 60);
    end
    @(negedge clk);
    wdata_we = 1'b0; ctrl_we = 1'b0;
    cyc_n(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vcu_responder.md
VCU_RESPONDER -- requirements
Module: vcu_responder

Interface
REQ-001 SHALL have parameter TICK_LOAD, 28 bits, default 28'h2FAF080; the tick reload value (simulation uses 28'h10).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two, range 2..8; the depth of the display-data FIFO.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous reset, active low.
REQ-005 SHALL have port vcu_reg_control, input, 32 bits; the control word from the CPU.
REQ-006 SHALL have port vcu_reg_control_we, input, 1 bit; strobes the control word for one cycle.
REQ-007 SHALL have port vcu_reg_wdata, input, 32 bits; write data from the CPU (bits [7:0] used).
REQ-008 SHALL have port vcu_reg_wdata_we, input, 1 bit; strobes the write data for one cycle.
REQ-009 SHALL have port vcu_reg_rdata, output, 32 bits; the status word read by the CPU.
REQ-010 SHALL have port disp_data, output, 8 bits; the byte presented to the display sink.
REQ-011 SHALL have port disp_valid, output, 1 bit; disp_data is valid.
REQ-012 SHALL have port disp_ready, input, 1 bit; the sink accepts the byte.

Function
REQ-013 Control bits on control_we SHALL be: [0] enable (registered, held); [1] flush FIFO (pulse); [2] tick restart (pulse); [3] clear overflow (pulse); bits [31:4] ignored.
REQ-014 Tick counter (28 bits) SHALL load TICK_LOAD on reset, on wdata_we, on control bit 2, and on display handshake completion, and SHALL decrement each cycle while bit 27 = 0.
REQ-015 tick_done SHALL equal counter bit 27, asserting TICK_LOAD+1 cycles after a load and holding until the next load.
REQ-016 wdata_we SHALL push wdata[7:0] into the FIFO when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-017 A push into a full FIFO with no simultaneous pop SHALL be dropped and SHALL set the sticky overflow flag; control bit 3 clears the flag, and a set takes priority over a clear in the same cycle.
REQ-018 Flush SHALL empty the FIFO in one cycle; a push in the same cycle as a flush SHALL be discarded without setting overflow.
REQ-019 The FSM SHALL have two states, IDLE and PRESENT.
REQ-020 IDLE->PRESENT SHALL occur when enable=1, FIFO is not empty and tick_done=1; that cycle pops the FIFO head into disp_data.
REQ-021 disp_valid SHALL be 1 exactly in PRESENT, and disp_data SHALL be stable while disp_valid=1.
REQ-022 PRESENT->IDLE SHALL occur on the first cycle with disp_ready=1; that cycle reloads the tick and latches disp_data into last_byte.
REQ-023 Clearing enable or flushing during PRESENT SHALL NOT abort the presented byte; it is held until accepted.
REQ-024 vcu_reg_rdata SHALL be registered (1-cycle latency) with fields: [0] tick_done, [1] empty, [2] full, [3] overflow, [7:4] FIFO count (zero-extended), [15:8] last_byte, [16] disp_valid, [31:17] = 0.
REQ-025 Minimum spacing between accepted bytes SHALL be TICK_LOAD+2 cycles.

Reset
REQ-026 On rst_n=0 the block SHALL immediately set: FIFO empty, pointers 0, overflow 0, enable 0, FSM IDLE, tick counter = TICK_LOAD, disp_valid 0, disp_data 8'h00, last_byte 8'h00, vcu_reg_rdata 32'h0000_0002.
REQ-027 Reset asserted mid-PRESENT SHALL drop the byte; disp_valid SHALL deassert asynchronously.
REQ-028 Reset SHALL be released synchronously by the upstream synchronizer; the block SHALL add no synchronizer of its own.

Structure
REQ-029 Package vcu_pkg SHALL hold the FSM state enum, the control bit indices, the status field positions, and the default TICK_LOAD constant.
REQ-030 The FIFO SHALL be the separate sub-module vcu_fifo (parameterised depth, 8-bit data, push, pop, flush, full, empty, count outputs).

Verification (TICK_LOAD=16, FIFO_DEPTH=4)
REQ-031 Release reset, no writes -> rdata=32'h2 until cycle 17 after release, then bit 0=1 (rdata=32'h3).
REQ-032 Push 8'hA5, write control 32'h1, disp_ready=1 -> after tick_done, disp_valid for 1 cycle with disp_data=8'hA5; rdata[15:8]=8'hA5.
REQ-033 Push 5 bytes 01..05 with enable=0 -> full=1, count=4, overflow=1; write control 32'h8 -> overflow=0, FIFO contents 01..04 unchanged.
REQ-034 Enable with 3 bytes queued and disp_ready held 0 for 10 cycles -> disp_data stable for those 10 cycles; accepted bytes are spaced at least 18 cycles apart.
REQ-035 Full FIFO, pop and push in the same cycle -> push accepted, count stays 4, overflow stays 0.
REQ-036 Assert rst_n=0 during PRESENT -> disp_valid=0 in the same cycle; rdata=32'h2 after release.
